// File: rtl/spi_config_assembler_pkg.sv
// Shared constants for the SPI configuration assembler: FSM state encoding,
// default command bytes and the field layout of the committed config word.
package spi_config_assembler_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_WDATA  = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam int         DEF_DATA_BYTES = 4;
    localparam logic [7:0] DEF_CMD_WRITE  = 8'hA0;
    localparam logic [7:0] DEF_CMD_READ   = 8'hB0;

    // Field layout of the 32-bit config word seen by the pixel mux.
    localparam int CFG_SEL_MSB = 31;
    localparam int CFG_SEL_LSB = 30;
    localparam int CFG_COL_MSB = 29;
    localparam int CFG_COL_LSB = 24;

endpackage

// File: rtl/spi_config_assembler_byte_shifter.sv
// MSB-first byte shift register with a fill counter; load clears it, shift
// appends a byte until BYTES have been taken. Result is visible next cycle.
module cfg_byte_shifter #(
    parameter int BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         shift,
    input  logic [7:0]                   din,
    output logic [8*BYTES-1:0]           dout,
    output logic [$clog2(BYTES+1)-1:0]   count,
    output logic                         full
);

    localparam int W     = 8 * BYTES;
    localparam int CNT_W = $clog2(BYTES + 1);

    logic [W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (load) begin
            shadow_d = '0;
            count_d  = '0;
        end else if (shift) begin
            shadow_d = (shadow_q << 8) | W'(din);
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    assign dout  = shadow_q;
    assign count = count_q;
    assign full  = (count_q == CNT_W'(BYTES));

endmodule

// File: rtl/spi_config_assembler.sv
// Frames SPI bytes by ss_n, decodes write/read commands and commits the config word atomically
// (outputs registered, one cycle after rx_valid; no backpressure). CONFIG_CHECKSUM_EN adds an XOR checksum byte.
module spi_config_assembler
    import spi_config_assembler_pkg::*;
#(
    parameter int                          DATA_BYTES   = DEF_DATA_BYTES,
    parameter logic [7:0]                  CMD_WRITE    = DEF_CMD_WRITE,
    parameter logic [7:0]                  CMD_READ     = DEF_CMD_READ,
    parameter logic [8*DATA_BYTES-1:0]     RESET_CONFIG = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ss_n,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_valid,
    output logic [7:0]                  tx_byte,
    output logic                        tx_load,
    output logic [8*DATA_BYTES-1:0]     config_word,
    output logic                        config_update,
    output logic                        frame_err
);

    localparam int                CW      = 8 * DATA_BYTES;
    localparam int                CNT_W   = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0]  N_BYTES = CNT_W'(DATA_BYTES);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    config_q, config_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_load_q, tx_load_d;
    logic             update_q, update_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic             sh_load, sh_shift, sh_full;
    logic [CW-1:0]    sh_dout;
    logic [CNT_W-1:0] sh_count;
    logic [CW-1:0]    rd_word;

`ifdef CONFIG_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES - 1);
    logic [CW-1:0]    merged;
    assign merged = (sh_dout << 8) | CW'(rx_byte);
`endif

    cfg_byte_shifter #(.BYTES(DATA_BYTES)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (rx_byte),
        .dout  (sh_dout),
        .count (sh_count),
        .full  (sh_full)
    );

    // Byte rd_cnt_q (MSB first) lands in the top byte of rd_word.
    assign rd_word = config_q << {rd_cnt_q, 3'b000};

    always_comb begin
        state_d   = state_q;
        config_d  = config_q;
        tx_byte_d = tx_byte_q;
        rd_cnt_d  = rd_cnt_q;
        tx_load_d = 1'b0;
        update_d  = 1'b0;
        err_d     = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (ss_n) begin
            // Deselect wins over a same-cycle byte; a partial write is an abort.
            state_d = ST_IDLE;
            sh_load = 1'b1;
            if (state_q == ST_WDATA) err_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (rx_valid) begin
                        if (rx_byte == CMD_WRITE) begin
                            state_d = ST_WDATA;
                            sh_load = 1'b1;
`ifdef CONFIG_CHECKSUM_EN
                            csum_d  = rx_byte;
`endif
                        end else if (rx_byte == CMD_READ) begin
                            state_d   = ST_RDATA;
                            tx_byte_d = config_q[CW-1 -: 8];
                            tx_load_d = 1'b1;
                            rd_cnt_d  = CNT_W'(1);
                        end else begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
`ifdef CONFIG_CHECKSUM_EN
                        if (!sh_full) begin
                            sh_shift = 1'b1;
                            csum_d   = csum_q ^ rx_byte;
                        end else begin
                            state_d = ST_DONE;
                            if (rx_byte == csum_q) begin
                                config_d = sh_dout;
                                update_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`else
                        sh_shift = !sh_full;
                        if (sh_count == LAST_IDX) begin
                            config_d = merged;
                            update_d = 1'b1;
                            state_d  = ST_DONE;
                        end
`endif
                    end
                end
                ST_RDATA: begin
                    if (rx_valid) begin
                        tx_load_d = 1'b1;
                        if (rd_cnt_q < N_BYTES) begin
                            tx_byte_d = rd_word[CW-1 -: 8];
                            rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                        end else begin
                            tx_byte_d = 8'h00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            config_q  <= RESET_CONFIG;
            tx_byte_q <= 8'h00;
            tx_load_q <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
`ifdef CONFIG_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            config_q  <= config_d;
            tx_byte_q <= tx_byte_d;
            tx_load_q <= tx_load_d;
            update_q  <= update_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
`ifdef CONFIG_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign tx_byte       = tx_byte_q;
    assign tx_load       = tx_load_q;
    assign config_word   = config_q;
    assign config_update = update_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_spi_config_assembler.sv
// Directed bench for spi_config_assembler: write, read-back, abort, unknown command,
// collision, trailing bytes, mid-frame reset and (when enabled) checksum frames.
module tb_spi_config_assembler;
    import spi_config_assembler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [31:0] config_word;
    logic        config_update;
    logic        frame_err;

    int n_pass  = 0;
    int n_total = 0;

    int upd_seen  = 0;
    int err_seen  = 0;
    int load_seen = 0;
    logic [7:0] tx_log[$];

    always #5 clk = ~clk;

    spi_config_assembler dut (
        .clk           (clk),
        .rst           (rst),
        .ss_n          (ss_n),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .tx_byte       (tx_byte),
        .tx_load       (tx_load),
        .config_word   (config_word),
        .config_update (config_update),
        .frame_err     (frame_err)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (config_update) upd_seen++;
        if (frame_err) err_seen++;
        if (tx_load) begin
            load_seen++;
            tx_log.push_back(tx_byte);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        cyc();
    endtask

    task automatic open_frame();
        ss_n = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic close_frame();
        ss_n = 1'b1;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic write_frame(input logic [31:0] w);
        logic [7:0] cs;
        cs = 8'hA0;
        open_frame();
        send(8'hA0);
        for (int i = 3; i >= 0; i--) begin
            send(w[8*i +: 8]);
            cs = cs ^ w[8*i +: 8];
        end
`ifdef CONFIG_CHECKSUM_EN
        send(cs);
`endif
        close_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1; ss_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        cyc(); cyc(); cyc();
        n_total++; if (config_word !== 32'h0) $display("FAIL reset_config: got %h want %h", config_word, 32'h0); else n_pass++;
        n_total++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want %h", tx_byte, 8'h00); else n_pass++;
        n_total++; if (tx_load !== 1'b0) $display("FAIL reset_tx_load: got %b want 0", tx_load); else n_pass++;
        n_total++; if (config_update !== 1'b0) $display("FAIL reset_update: got %b want 0", config_update); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int u0, e0;
        logic [7:0] last;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'hC3); send(8'h12); send(8'h34);
`ifdef CONFIG_CHECKSUM_EN
        send(8'h56);
        last = 8'h13;   // A0^C3^12^34^56
`else
        last = 8'h56;
`endif
        rx_byte = last; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        n_total++; if (config_word !== 32'hC312_3456) $display("FAIL write_latency_data: got %h want %h", config_word, 32'hC312_3456); else n_pass++;
        n_total++; if (config_update !== 1'b1) $display("FAIL write_latency_update: got %b want 1", config_update); else n_pass++;
        cyc();
        n_total++; if (config_update !== 1'b0) $display("FAIL write_update_width: got %b want 0", config_update); else n_pass++;
        close_frame();
        n_total++; if (upd_seen - u0 !== 1) $display("FAIL write_update_count: got %0d want 1", upd_seen - u0); else n_pass++;
        n_total++; if (err_seen - e0 !== 0) $display("FAIL write_no_err: got %0d want 0", err_seen - e0); else n_pass++;
        n_total++; if (config_word[CFG_SEL_MSB:CFG_SEL_LSB] !== 2'b11) $display("FAIL write_select_field: got %b want 11", config_word[CFG_SEL_MSB:CFG_SEL_LSB]); else n_pass++;
        n_total++; if (config_word[CFG_COL_MSB:CFG_COL_LSB] !== 6'h03) $display("FAIL write_colour_field: got %h want 03", config_word[CFG_COL_MSB:CFG_COL_LSB]); else n_pass++;
    endtask

    task automatic test_readback();
        int t0, l0, e0;
        logic [7:0] exp_bytes [5];
        exp_bytes[0] = 8'hC3; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h34;
        exp_bytes[3] = 8'h56; exp_bytes[4] = 8'h00;
        t0 = tx_log.size(); l0 = load_seen; e0 = err_seen;
        open_frame();
        send(8'hB0);
        for (int i = 0; i < 4; i++) send(8'h00);
        close_frame();
        n_total++; if (load_seen - l0 !== 5) $display("FAIL read_load_count: got %0d want 5", load_seen - l0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (t0 + i >= tx_log.size()) $display("FAIL read_byte_%0d: got none want %h", i, exp_bytes[i]);
            else if (tx_log[t0 + i] !== exp_bytes[i]) $display("FAIL read_byte_%0d: got %h want %h", i, tx_log[t0 + i], exp_bytes[i]);
            else n_pass++;
        end
        n_total++; if (err_seen - e0 !== 0) $display("FAIL read_no_err: got %0d want 0", err_seen - e0); else n_pass++;
    endtask

    task automatic test_abort();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'hFF); send(8'hFF);
        close_frame();
        n_total++; if (err_seen - e0 !== 1) $display("FAIL abort_err_count: got %0d want 1", err_seen - e0); else n_pass++;
        n_total++; if (upd_seen - u0 !== 0) $display("FAIL abort_no_update: got %0d want 0", upd_seen - u0); else n_pass++;
        n_total++; if (config_word !== 32'hC312_3456) $display("FAIL abort_config_kept: got %h want %h", config_word, 32'hC312_3456); else n_pass++;
        u0 = upd_seen; e0 = err_seen;
        write_frame(32'h1122_3344);
        n_total++; if (config_word !== 32'h1122_3344) $display("FAIL abort_rewrite_data: got %h want %h", config_word, 32'h1122_3344); else n_pass++;
        n_total++; if (upd_seen - u0 !== 1) $display("FAIL abort_rewrite_update: got %0d want 1", upd_seen - u0); else n_pass++;
        n_total++; if (err_seen - e0 !== 0) $display("FAIL abort_rewrite_err: got %0d want 0", err_seen - e0); else n_pass++;
    endtask

    task automatic test_unknown_cmd();
        int u0, e0, l0;
        u0 = upd_seen; e0 = err_seen; l0 = load_seen;
        open_frame();
        rx_byte = 8'h5A; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        n_total++; if (frame_err !== 1'b1) $display("FAIL unknown_err_at_cmd: got %b want 1", frame_err); else n_pass++;
        cyc();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        close_frame();
        n_total++; if (err_seen - e0 !== 1) $display("FAIL unknown_err_count: got %0d want 1", err_seen - e0); else n_pass++;
        n_total++; if (upd_seen - u0 !== 0) $display("FAIL unknown_no_update: got %0d want 0", upd_seen - u0); else n_pass++;
        n_total++; if (load_seen - l0 !== 0) $display("FAIL unknown_no_tx_load: got %0d want 0", load_seen - l0); else n_pass++;
        n_total++; if (config_word !== 32'h1122_3344) $display("FAIL unknown_config_kept: got %h want %h", config_word, 32'h1122_3344); else n_pass++;
    endtask

    task automatic test_collision();
        int u0, e0;
        logic [7:0] last;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'hAA); send(8'hBB); send(8'hCC);
`ifdef CONFIG_CHECKSUM_EN
        send(8'hDD);
        last = 8'hA0 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD;
`else
        last = 8'hDD;
`endif
        rx_byte = last; rx_valid = 1'b1; ss_n = 1'b1;
        cyc();
        rx_valid = 1'b0;
        cyc(); cyc();
        n_total++; if (err_seen - e0 !== 1) $display("FAIL collision_err_count: got %0d want 1", err_seen - e0); else n_pass++;
        n_total++; if (upd_seen - u0 !== 0) $display("FAIL collision_no_update: got %0d want 0", upd_seen - u0); else n_pass++;
        n_total++; if (config_word !== 32'h1122_3344) $display("FAIL collision_config_kept: got %h want %h", config_word, 32'h1122_3344); else n_pass++;
    endtask

    task automatic test_trailing();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef CONFIG_CHECKSUM_EN
        send(8'hA0 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        send(8'h99); send(8'h99);
        close_frame();
        n_total++; if (config_word !== 32'hDEAD_BEEF) $display("FAIL trailing_data: got %h want %h", config_word, 32'hDEAD_BEEF); else n_pass++;
        n_total++; if (upd_seen - u0 !== 1) $display("FAIL trailing_update_count: got %0d want 1", upd_seen - u0); else n_pass++;
        n_total++; if (err_seen - e0 !== 0) $display("FAIL trailing_no_err: got %0d want 0", err_seen - e0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        open_frame();
        send(8'hB0);
        close_frame();
        n_total++; if (tx_byte !== 8'hDE) $display("FAIL midreset_pre_tx_byte: got %h want %h", tx_byte, 8'hDE); else n_pass++;
        open_frame();
        send(8'hA0); send(8'h01); send(8'h02);
        rst = 1'b1;
        cyc();
        n_total++; if (config_word !== 32'h0) $display("FAIL midreset_config: got %h want %h", config_word, 32'h0); else n_pass++;
        n_total++; if (tx_byte !== 8'h00) $display("FAIL midreset_tx_byte: got %h want %h", tx_byte, 8'h00); else n_pass++;
        n_total++; if (tx_load !== 1'b0) $display("FAIL midreset_tx_load: got %b want 0", tx_load); else n_pass++;
        n_total++; if (config_update !== 1'b0) $display("FAIL midreset_update: got %b want 0", config_update); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL midreset_frame_err: got %b want 0", frame_err); else n_pass++;
        ss_n = 1'b1;
        rst  = 1'b0;
        cyc(); cyc();
        n_total++; if (config_word !== 32'h0) $display("FAIL midreset_frame_discarded: got %h want %h", config_word, 32'h0); else n_pass++;
    endtask

`ifdef CONFIG_CHECKSUM_EN
    task automatic test_checksum();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hA5);
        close_frame();
        n_total++; if (err_seen - e0 !== 1) $display("FAIL csum_bad_err: got %0d want 1", err_seen - e0); else n_pass++;
        n_total++; if (upd_seen - u0 !== 0) $display("FAIL csum_bad_no_update: got %0d want 0", upd_seen - u0); else n_pass++;
        n_total++; if (config_word !== 32'h0) $display("FAIL csum_bad_config: got %h want %h", config_word, 32'h0); else n_pass++;
        u0 = upd_seen; e0 = err_seen;
        open_frame();
        send(8'hA0); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hA4);
        close_frame();
        n_total++; if (config_word !== 32'h0102_0304) $display("FAIL csum_good_config: got %h want %h", config_word, 32'h0102_0304); else n_pass++;
        n_total++; if (upd_seen - u0 !== 1) $display("FAIL csum_good_update: got %0d want 1", upd_seen - u0); else n_pass++;
        n_total++; if (err_seen - e0 !== 0) $display("FAIL csum_good_no_err: got %0d want 0", err_seen - e0); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; ss_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        test_reset();
        test_write();
        test_readback();
        test_abort();
        test_unknown_cmd();
        test_collision();
        test_trailing();
        test_reset_mid_frame();
`ifdef CONFIG_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_config_assembler.md
Name: spi_config_assembler

Overview:
- Sits between SPI_Peripheral and the configuration register that drives pixel_mux select and colour.
- Consumes the SPI byte stream, frames it by chip select and decodes a command byte.
- Assembles a multi-byte configuration word and commits it atomically, so the mux never sees a partial word.
- Also serves read-back bytes to the SPI transmit path.

Parameters:
- DATA_BYTES, 4, payload bytes per write/read frame; config width = 8*DATA_BYTES.
- CMD_WRITE, 8'hA0, command byte opening a write frame.
- CMD_READ, 8'hB0, command byte opening a read frame.
- RESET_CONFIG, 32'h0000_0000, config_word value after reset (width 8*DATA_BYTES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ss_n  in  1  chip select, active low, already synchronous to clk.
- rx_byte  in  8  byte received from SPI_Peripheral.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- tx_byte  out  8  next byte for SPI_Peripheral to shift out.
- tx_load  out  1  one-cycle strobe; tx_byte has been updated.
- config_word  out  8*DATA_BYTES  committed configuration word.
- config_update  out  1  one-cycle pulse when config_word changes.
- frame_err  out  1  one-cycle pulse on aborted or unknown frame.

Behaviour:
- Clocking and reset: single clock, synchronous active-high rst.
- Reset values: state=IDLE, config_word=RESET_CONFIG, tx_byte=8'h00, tx_load=0, config_update=0, frame_err=0, shadow register=0, byte counter=0.
- Reset mid-frame discards the frame; config_word returns to RESET_CONFIG.

State machine (registered):
- IDLE: ss_n=0 -> CMD. rx_valid is ignored while ss_n=1.
- CMD, on rx_valid:
  - rx_byte==CMD_WRITE -> WDATA, counter=0.
  - rx_byte==CMD_READ -> RDATA; tx_byte=config_word[MSB byte]; tx_load=1; counter=1.
  - Any other byte -> IGNORE; frame_err=1.
- WDATA, on rx_valid:
  - Shift the byte into the shadow register, MSB first; counter++.
  - On byte DATA_BYTES: config_word<=shadow with the final byte merged in, config_update=1, go to DONE.
  - Latency: config_word and config_update are valid the cycle after the final rx_valid.
- RDATA, on rx_valid:
  - counter<DATA_BYTES: tx_byte=config_word byte[counter] (MSB first), tx_load=1, counter++.
  - Otherwise tx_byte=8'h00, tx_load=1, stay in RDATA.
- DONE / IGNORE: further rx_valid bytes are ignored; wait for ss_n=1.
- ss_n=1 from any state -> IDLE, next cycle.
  - From WDATA (partial payload) it also pulses frame_err; config_word is unchanged and the shadow is discarded.
  - From CMD with no byte received, no error.

Boundary and priority rules:
- rx_valid in the same cycle as ss_n=1: ss_n wins, the byte is dropped, and the abort rule applies.
- A write frame with extra trailing bytes: commit happens after byte DATA_BYTES; the trailing bytes are ignored.
- Outputs never change between frames except on reset.

Optional Feature:
- Macro: CONFIG_CHECKSUM_EN.
- Defined: write frames carry one extra byte after the payload, equal to the XOR of the command byte and all payload bytes.
  - Commit happens only on a match, the cycle after the checksum byte.
  - Mismatch -> frame_err pulse, config_word unchanged, go to DONE.
  - ss_n=1 before the checksum byte arrives counts as an abort.
- Undefined: no checksum byte; commit happens after the last payload byte as described above.
- Read frames are identical with or without the macro.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CMD, WDATA, RDATA, DONE, IGNORE);
  - the CMD_WRITE/CMD_READ default constants;
  - the config field layout constants: select=[31:30], colour=[29:24].
- One natural sub-module: cfg_byte_shifter. It is a shift register with a counter, exposing load, shift, count and full, and is used by WDATA.
- The FSM and read mux stay in the top module.

Test Plan:
- Write: ss_n low; bytes A0, C3, 12, 34, 56; ss_n high -> config_word=32'hC3123456 one cycle after the last rx_valid; config_update high for exactly 1 cycle; frame_err never asserted.
- Read-back: after the write above, ss_n low; bytes B0, 00, 00, 00, 00 -> tx_load pulses 5 times; tx_byte sequence C3, 12, 34, 56, 00.
- Abort: bytes A0, FF, FF then ss_n high -> frame_err 1 pulse; config_word stays C3123456; a following full write succeeds.
- Unknown command: byte 5A then bytes 11, 22, 33, 44 -> frame_err 1 pulse at the command byte; no config_update; no tx_load.
- Collision: rx_valid on the final write byte in the same cycle ss_n rises -> byte dropped, frame_err pulse, no commit.
- Reset: rst asserted mid-WDATA -> next cycle all outputs at reset values, config_word=0. With CONFIG_CHECKSUM_EN defined, frame A0, 01, 02, 03, 04, checksum A4 commits; checksum A5 gives frame_err and no commit.
